stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 45 ++++
 rtl/stopwatch_core_tick_gen.sv | 28 ++
 rtl/stopwatch_core.sv | 105 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM state encoding,
// BCD digit types, per-digit limits and the cascaded BCD increment helpers.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [3:0] digits_t;

  // [0] tenths, [1] seconds ones, [2] seconds tens, [3] minutes
  localparam digits_t DIGIT_MAX = {4'd9, 4'd5, 4'd9, 4'd9};

  // ">=" rather than "==" so an out-of-range digit can never persist
  function automatic digits_t bcd_inc(input digits_t d);
    digits_t r;
    logic    carry;
    r     = d;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (d[i] >= DIGIT_MAX[i]) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = d[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_all_max(input digits_t d);
    logic m;
    m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (d[i] != DIGIT_MAX[i]) m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// Prescaler: counts TICK_CYCLES enabled cycles and flags the terminal one.
// Holds while en is low; clr zeroes it and suppresses the tick.
module tick_gen #(
  parameter int TICK_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: run/pause FSM, cascaded BCD count m:ss.t, rollover pulse.
// Optional lap freeze of the displayed digits when STOPWATCH_LAP_EN is defined.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 10,
  parameter int TICK_NS       = 100_000_000
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    start_pulse_i,
  input  logic    clear_pulse_i,
  input  logic    lap_pulse_i,
  output digits_t digits_o,
  output logic    running_o,
  output logic    wrap_o
);

  localparam int TICK_CYCLES = TICK_NS / CLK_PERIOD_NS;

  state_t  state;
  digits_t count;
  logic    tick;
  logic    prescale_en;
  logic    prescale_clr;

  assign prescale_en  = (state == RUN);
  assign prescale_clr = clear_pulse_i || (state == IDLE);

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk (clk_i),
    .rst (rst_i),
    .en  (prescale_en),
    .clr (prescale_clr),
    .tick(tick)
  );

  // Clear outranks start/lap; a tick taken in the same cycle as a pause
  // still counts because the prescaler was enabled on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      count     <= '0;
      running_o <= 1'b0;
      wrap_o    <= 1'b0;
    end else begin
      wrap_o <= 1'b0;
      if (clear_pulse_i) begin
        state     <= IDLE;
        count     <= '0;
        running_o <= 1'b0;
      end else begin
        if (tick) begin
          count  <= bcd_inc(count);
          wrap_o <= bcd_all_max(count);
        end
        if (start_pulse_i) begin
          case (state)
            IDLE, PAUSE: begin
              state     <= RUN;
              running_o <= 1'b1;
            end
            RUN: begin
              state     <= PAUSE;
              running_o <= 1'b0;
            end
            default: begin
              state     <= IDLE;
              running_o <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic    frozen;
  digits_t lap_count;

  // Lap toggles only while running; the snapshot survives a pause
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_pulse_i) begin
      frozen <= 1'b0;
    end else if (lap_pulse_i && (state == RUN)) begin
      frozen <= !frozen;
    end
  end

  always_ff @(posedge clk_i) begin
    if (lap_pulse_i && (state == RUN) && !frozen) begin
      lap_count <= count;
    end
  end

  assign digits_o = frozen ? lap_count : count;
`else
  logic unused_lap;
  assign unused_lap = lap_pulse_i;
  assign digits_o   = count;
`endif

endmodule
